// File: rtl/mul_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding,
// FSM state encoding and operand-signedness helpers.
package mul_div_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mdu_state_e;

  function automatic logic op_a_signed(input logic [2:0] op);
    return op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return op inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
  endfunction

endpackage

// File: rtl/mul_div_ctrl.sv
// Sequencer for the multiply/divide unit: FSM plus iteration counter.
//   state | meaning
//   IDLE  | waiting for start
//   CALC  | one radix-2 iteration per edge, WIDTH edges in total
//   FIX   | sign correction, y registered on the exit edge
//   DONE  | y valid, done high; start here is accepted immediately
module mul_div_ctrl
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic bypass_i,
  output logic busy_o,
  output logic done_o,
  output logic accept_o,
  output logic step_o,
  output logic fix_o
);

  localparam int CW = $clog2(WIDTH + 1);

  mdu_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (start_i) begin
            cnt_q <= '0;
            if (bypass_i) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= CALC;
              busy_q  <= 1'b1;
            end
          end
        end
        CALC: begin
          cnt_q <= cnt_q + CW'(1);
          // counter lands on WIDTH on the same edge that enters FIX
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign accept_o = reset && start_i && ((state_q == IDLE) || (state_q == DONE));
  assign step_o   = (state_q == CALC);
  assign fix_o    = (state_q == FIX);
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M-style multiply/divide unit: magnitude datapath with a
// shared 2*WIDTH+1 accumulator, sign fixup and one-cycle special-case bypass.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y
);

  localparam int AW = 2 * WIDTH + 1;

  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]   y_q, y_d;

  logic               accept, step, fix, bypass;
  logic               sa, sb, div0, ovf;
  logic [WIDTH-1:0]   mag_a, mag_b, bypass_y;
  logic [WIDTH:0]     mul_sum, div_diff;
  logic [AW-1:0]      mul_next, div_shl, div_next;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo, rmd, fix_y;

  mul_div_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start),
    .bypass_i (bypass),
    .busy_o   (busy),
    .done_o   (done),
    .accept_o (accept),
    .step_o   (step),
    .fix_o    (fix)
  );

  always_comb begin
    sa     = op_a_signed(op) & a[WIDTH-1];
    sb     = op_b_signed(op) & b[WIDTH-1];
    mag_a  = sa ? -a : a;
    mag_b  = sb ? -b : b;
    div0   = op[2] && (b == '0);
    ovf    = op[2] && !op[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (&b);
    bypass = div0 | ovf;
    if (div0) begin
      bypass_y = op[1] ? a : '1;
    end else begin
      bypass_y = op[1] ? '0 : a;
    end
  end

  // Multiply: add multiplicand into the upper half when the low bit is set, shift right.
  // Divide: shift left, subtract divisor from the upper half if it fits, set quotient bit.
  always_comb begin
    mul_sum  = acc_q[AW-1:WIDTH] + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_next = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
    div_shl  = {acc_q[AW-2:0], 1'b0};
    div_diff = div_shl[AW-1:WIDTH] - {1'b0, opnd_q};
    if (div_shl[AW-1:WIDTH] >= {1'b0, opnd_q}) begin
      div_next = {div_diff, div_shl[WIDTH-1:1], 1'b1};
    end else begin
      div_next = div_shl;
    end
  end

  always_comb begin
    prod_s = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    quo    = acc_q[WIDTH-1:0];
    rmd    = acc_q[2*WIDTH-1:WIDTH];
    fix_y  = '0;
    case (op_q)
      MDU_MUL:                         fix_y = prod_s[WIDTH-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_y = prod_s[2*WIDTH-1:WIDTH];
      MDU_DIV, MDU_DIVU:               fix_y = neg_q ? -quo : quo;
      default:                         fix_y = neg_q ? -rmd : rmd;
    endcase
  end

  always_comb begin
    op_d   = op_q;
    neg_d  = neg_q;
    opnd_d = opnd_q;
    acc_d  = acc_q;
    y_d    = y_q;
    if (accept) begin
      op_d   = op;
      // remainder follows the dividend's sign; everything else the xor of both
      neg_d  = (op[2] && op[1]) ? sa : (sa ^ sb);
      opnd_d = op[2] ? mag_b : mag_a;
      acc_d  = {{(WIDTH+1){1'b0}}, (op[2] ? mag_a : mag_b)};
      if (bypass) begin
        y_d = bypass_y;
      end
    end else if (step) begin
      acc_d = op_q[2] ? div_next : mul_next;
    end else if (fix) begin
      y_d = fix_y;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q   <= '0;
      neg_q  <= 1'b0;
      opnd_q <= '0;
      acc_q  <= '0;
      y_q    <= '0;
    end else begin
      op_q   <= op_d;
      neg_q  <= neg_d;
      opnd_q <= opnd_d;
      acc_q  <= acc_d;
      y_q    <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH=32): cycle-level latency model
// plus arithmetic reference, directed corner cases and random operations.
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done;
  logic [W-1:0] y;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .y     (y)
  );

  function automatic logic ref_bypass(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] d);
    return f[2] && ((d == 0) || (!f[0] && x == 32'h8000_0000 && d == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [W-1:0] ref_result(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] d);
    longint      sx, sd, ux, q;
    logic [63:0] p, ux64, ud64;
    sx = $signed(x);
    sd = $signed(d);
    ux = x;
    ux64 = x;
    ud64 = d;
    case (f)
      3'd0: begin p = sx * sd; return p[31:0]; end
      3'd1: begin p = sx * sd; return p[63:32]; end
      3'd2: begin p = sx * longint'(ud64); return p[63:32]; end
      3'd3: begin p = ux64 * ud64; return p[63:32]; end
      3'd4: begin
        if (d == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && d == 32'hFFFF_FFFF) return x;
        q = sx / sd; return q[31:0];
      end
      3'd5: begin
        if (d == 0) return 32'hFFFF_FFFF;
        return x / d;
      end
      3'd6: begin
        if (d == 0) return x;
        if (x == 32'h8000_0000 && d == 32'hFFFF_FFFF) return 32'd0;
        q = sx % sd; return q[31:0];
      end
      default: begin
        if (d == 0) return x;
        q = ux % longint'(ud64); return q[31:0];
      end
    endcase
  endfunction

  // Latency model: a normal op accepted at edge k is busy after edges k..k+W,
  // loads y and raises done after edge k+W+1; a bypass does both after edge k.
  int           edge_n = 0;
  int           free_edge = 0;
  int           done_edge = -1;
  int           busy_first = -1;
  int           busy_last = -1;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_y = '0;
  logic [W-1:0] pend_y = '0;
  bit           model_live = 1'b0;

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (!reset) begin
      model_live <= 1'b1;
      free_edge  <= edge_n + 1;
      done_edge  <= -1;
      busy_first <= -1;
      busy_last  <= -1;
      m_busy     <= 1'b0;
      m_done     <= 1'b0;
      m_y        <= '0;
    end else if (start && edge_n >= free_edge) begin
      if (ref_bypass(op, a, b)) begin
        done_edge  <= edge_n;
        busy_first <= -1;
        busy_last  <= -1;
        free_edge  <= edge_n + 1;
        m_busy     <= 1'b0;
        m_done     <= 1'b1;
        m_y        <= ref_result(op, a, b);
      end else begin
        done_edge  <= edge_n + W + 1;
        busy_first <= edge_n;
        busy_last  <= edge_n + W;
        free_edge  <= edge_n + W + 2;
        pend_y     <= ref_result(op, a, b);
        m_busy     <= 1'b1;
        m_done     <= 1'b0;
      end
    end else begin
      m_busy <= (edge_n >= busy_first) && (edge_n <= busy_last);
      m_done <= (edge_n == done_edge);
      if (edge_n == done_edge) m_y <= pend_y;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_live) begin
      check("cyc busy", busy, m_busy);
      check("cyc done", done, m_done);
      check("cyc y", y, m_y);
    end
  end

  task automatic run_op(input string nm, input logic [2:0] t_op, input logic [W-1:0] t_a,
                        input logic [W-1:0] t_b, input logic [W-1:0] exp_y,
                        input int exp_lat, input int exp_busy);
    int           lat = 0;
    int           bc = 0;
    bit           seen = 1'b0;
    logic [W-1:0] got = '0;
    @(posedge clk); #1;
    op = t_op; a = t_a; b = t_b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
      if (done) begin seen = 1'b1; got = y; end
    end
    check({nm, " done seen"}, seen, 1);
    if (seen) begin
      check({nm, " y"}, got, exp_y);
      check({nm, " latency"}, lat, exp_lat);
      check({nm, " busy cycles"}, bc, exp_busy);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    int           lat;
    int           bsy;
  } vec_t;

  vec_t         vecs[$];
  int           lat, dcount;
  bit           seen;
  logic [W-1:0] got;
  logic [2:0]   rop;
  logic [W-1:0] ra, rb;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset y", y, 0);

    vecs.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 33});
    vecs.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34, 33});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 33});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 33});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34, 33});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34, 33});
    vecs.push_back('{3'd5, 32'd100,        32'd0,         32'hFFFF_FFFF, 1, 0});
    vecs.push_back('{3'd7, 32'd100,        32'd0,         32'd100,       1, 0});
    vecs.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 0});
    vecs.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1, 0});
    vecs.push_back('{3'd5, 32'd100,        32'd7,         32'd14,        34, 33});
    vecs.push_back('{3'd7, 32'd100,        32'd7,         32'd2,         34, 33});
    vecs.push_back('{3'd0, 32'h0000_FFFF,  32'h0000_FFFF, 32'hFFFE_0001, 34, 33});
    vecs.push_back('{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 33});
    foreach (vecs[i])
      run_op($sformatf("dir%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].lat, vecs[i].bsy);

    // start during CALC must not disturb the running divu 1000/7
    @(posedge clk); #1;
    op = 3'd5; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    lat = 5;
    op = 3'd0; a = 32'd3; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0; got = '0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (done) begin seen = 1'b1; got = y; end
    end
    check("ignore done seen", seen, 1);
    check("ignore y", got, 32'd142);
    check("ignore latency", lat, 34);

    // reset in the middle of CALC aborts with no done
    @(posedge clk); #1;
    op = 3'd0; a = 32'd5; b = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort y", y, 0);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("abort no done", dcount, 0);

    // reset wins over start on the same edge
    @(negedge clk);
    op = 3'd5; a = 32'd5; b = 32'd0; start = 1'b1; reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    check("rst+start done", done, 0);
    check("rst+start busy", busy, 0);

    // back-to-back: start held through the first DONE cycle
    @(posedge clk); #1;
    op = 3'd0; a = 32'd3; b = 32'd4; start = 1'b1;
    seen = 1'b0; got = '0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; got = y; end
    end
    check("b2b first seen", seen, 1);
    check("b2b first y", got, 32'd12);
    a = 32'd10; b = 32'd10;
    lat = 0; seen = 1'b0; got = '0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (done) begin seen = 1'b1; got = y; start = 1'b0; end
    end
    start = 1'b0;
    check("b2b second seen", seen, 1);
    check("b2b second y", got, 32'd100);
    check("b2b spacing", lat, 34);

    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      run_op($sformatf("rand%0d op%0d a=%h b=%h", i, rop, ra, rb), rop, ra, rb,
             ref_result(rop, ra, rb), ref_bypass(rop, ra, rb) ? 1 : W + 2,
             ref_bypass(rop, ra, rb) ? 0 : W + 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits; legal values are 4 to 64.
REQ-002 The block SHALL have input clk, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have input reset, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have input start, 1 bit: request a new operation.
REQ-005 The block SHALL have input op, 3 bits: operation select using the RV32M funct3 encoding: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
REQ-006 The block SHALL have inputs a and b, WIDTH bits each: a is the multiplicand or dividend, b is the multiplier or divisor.
REQ-007 The block SHALL have output busy, 1 bit: high while an operation is in progress.
REQ-008 The block SHALL have output done, 1 bit: a one-cycle pulse marking y valid.
REQ-009 The block SHALL have output y, WIDTH bits: the result.

Function
REQ-010 The block SHALL use the FSM states IDLE, CALC, FIX and DONE.
REQ-011 The block SHALL accept start only in IDLE or DONE, capturing op, a and b on that edge (the accept edge, k).
REQ-012 The block SHALL ignore start while busy, leaving the operation in progress and its captured operands undisturbed.
REQ-013 On a normal accept the block SHALL enter CALC and perform exactly WIDTH radix-2 iterations, one per edge, on edges k+1..k+WIDTH: shift-add for multiply, restoring shift-subtract for divide.
REQ-014 The block SHALL treat mul, mulh and div/rem operands as signed, mulhsu as a signed a with an unsigned b, and mulhu, divu and remu as unsigned.
REQ-015 Signed operands SHALL be converted to magnitudes on the accept edge, with the iteration performed unsigned.
REQ-016 After CALC the block SHALL spend one cycle in FIX, which applies sign correction and registers y, then enter DONE.
REQ-017 For a normal operation, done SHALL be high for exactly the one cycle following edge k+WIDTH+1.
REQ-018 busy SHALL be high from the cycle after edge k through the FIX cycle, and low in IDLE and DONE.
REQ-019 mul SHALL return the low WIDTH bits of the 2*WIDTH-bit product; mulh, mulhsu and mulhu SHALL return the high WIDTH bits.
REQ-020 Division SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-021 For division by zero (b==0, ops 1xx) the block SHALL bypass CALC and FIX.
- Quotient: all ones.
- Remainder: a.
- Timing: enter DONE on edge k, with done high in the cycle after edge k.
REQ-022 For signed overflow (div/rem with a = the most negative value and b = all ones) the block SHALL bypass CALC and FIX.
- Quotient: a.
- Remainder: 0.
- Timing: same as REQ-021.
REQ-023 y SHALL hold its value from the done cycle until the next FIX or bypass load.
REQ-024 DONE SHALL return to IDLE on the next edge unless start is high, in which case that edge is a new accept edge (back-to-back operation).
REQ-025 The iteration counter SHALL be ceil(log2(WIDTH+1)) bits wide, and the CALC-to-FIX transition SHALL occur when it reaches WIDTH.
REQ-026 The internal accumulator SHALL be 2*WIDTH+1 bits wide so that no iteration overflows.

Reset
REQ-027 When reset is low on a rising clk edge, the block SHALL enter IDLE with busy=0, done=0, y=0 and the iteration counter at 0.
REQ-028 Reset asserted mid-operation (CALC or FIX) SHALL abort the operation, with no done pulse for the aborted operation.
REQ-029 When reset is low on the same edge as start=1, reset SHALL take priority and start SHALL be ignored.

Structure
REQ-030 A shared package SHALL hold the op encoding constants (MDU_MUL..MDU_REMU) and the state encoding (IDLE, CALC, FIX, DONE).
REQ-031 The FSM and iteration counter SHALL be a single sub-module, mul_div_ctrl; the operand registers, accumulator and sign fixup SHALL remain in mul_div_unit.

Verification
REQ-032 Scenario: WIDTH=32, mul with a=7, b=0xFFFFFFFD -> y=0xFFFFFFEB, with done pulsed in the cycle after edge k+33 and busy high for 33 cycles.
REQ-033 Scenario: mulh with a=b=0x80000000 -> y=0x40000000; mulhu with a=b=0xFFFFFFFF -> y=0xFFFFFFFE; mulhsu with a=0xFFFFFFFF, b=0xFFFFFFFF -> y=0xFFFFFFFF.
REQ-034 Scenario: div with a=0xFFFFFFF9 (-7), b=2 -> y=0xFFFFFFFD; rem with the same operands -> y=0xFFFFFFFF.
REQ-035 Scenario: divu with a=100, b=0 -> y=0xFFFFFFFF; remu with a=100, b=0 -> y=100; in both cases done is high in the cycle after the accept edge and busy is never high.
REQ-036 Scenario: div with a=0x80000000, b=0xFFFFFFFF -> y=0x80000000; rem with the same operands -> y=0; both complete on the one-cycle bypass path.
REQ-037 Scenario: start with new operands at CALC iteration 5 -> ignored, with the original result delivered; reset low at CALC iteration 10 -> busy=0, done=0, y=0 on the next cycle and no done pulse follows; start held high in DONE -> back-to-back operation with the second done exactly 34 cycles after the first.
